// File: rtl/wishbone_gpio_bank.sv
// wishbone_gpio_bank: Wishbone-mapped GPIO channels with lane-masked set/clear/toggle writes,
// synchronised inputs, rising-edge W1C status and a registered interrupt.
module wishbone_gpio_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int CHANNELS = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PAT = '0,
    parameter int SYNC_STAGES = 2,
    parameter logic [1:0] TGD = 2'h0,
    localparam int SB = $clog2(SELECT_WIDTH),
    localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW = SB + 4 + CB,
    localparam int W = CHANNELS * DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic [AW-1:0]           adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    we_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    rty_o,
    output logic [1:0]              tgd_o,
    input  logic [W-1:0]            in_i,
    output logic [W-1:0]            out_o,
    output logic                    irq_o
);
    localparam int G = DATA_WIDTH / SELECT_WIDTH;
    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t out_q [CHANNELS];
    word_t out_d [CHANNELS];
    word_t en_q [CHANNELS];
    word_t en_d [CHANNELS];
    word_t stat_q [CHANNELS];
    word_t stat_d [CHANNELS];
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] prev_q, rise;
    logic ack_q, err_q, irq_q, irq_d;
    word_t dat_q, dat_d, mask;
    logic [1:0] mode, rsel;
    logic [CB-1:0] ch;
    logic req, bad, wr, rd;

    function automatic word_t upd(word_t r, word_t d, word_t m, logic [1:0] md);
        return (r & ~m) | ((md == 2'd0 ? d : md == 2'd1 ? r | d : md == 2'd2 ? r & ~d : r ^ d) & m);
    endfunction

    assign mode = adr_i[SB+1:SB];
    assign rsel = adr_i[SB+3:SB+2];
    assign ch = adr_i[AW-1:SB+4];
    assign req = cyc_i & stb_i & ~ack_q & ~err_q;
    assign bad = (32'(ch) >= 32'(CHANNELS)) | (we_i & (rsel == 2'd1));
    assign wr = req & ~bad & we_i;
    assign rd = req & ~bad & ~we_i;
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < SELECT_WIDTH; i++) mask[i*G +: G] = {G{sel_i[i]}};
    end

    always_comb begin
        dat_d = '0;
        irq_d = 1'b0;
        out_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_d[c] = (wr && ch == CB'(c) && rsel == 2'd0) ? upd(out_q[c], dat_i, mask, mode) : out_q[c];
            en_d[c] = (wr && ch == CB'(c) && rsel == 2'd3) ? upd(en_q[c], dat_i, mask, mode) : en_q[c];
            // a new rising edge wins over a simultaneous clear
            stat_d[c] = (stat_q[c] & ~((wr && ch == CB'(c) && rsel == 2'd2) ? mask : '0))
                      | rise[c*DATA_WIDTH +: DATA_WIDTH];
            dat_d = dat_d | ((rd && ch == CB'(c)) ? (rsel == 2'd0 ? out_q[c] :
                    rsel == 2'd1 ? sync_q[SYNC_STAGES-1][c*DATA_WIDTH +: DATA_WIDTH] :
                    rsel == 2'd2 ? stat_q[c] : en_q[c]) : '0);
            irq_d = irq_d | (|(stat_q[c] & en_q[c]));
            out_o[c*DATA_WIDTH +: DATA_WIDTH] = out_q[c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            out_q <= '{default: RESET_PAT};
            en_q <= '{default: '0};
            stat_q <= '{default: '0};
            sync_q <= '0;
            prev_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            out_q <= out_d;
            en_q <= en_d;
            stat_q <= stat_d;
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            ack_q <= req & ~bad;
            err_q <= req & bad;
            dat_q <= dat_d;
            irq_q <= irq_d;
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign irq_o = irq_q;
    assign rty_o = 1'b0;
    assign tgd_o = TGD;
endmodule

// File: tb/tb_wishbone_gpio_bank.sv
// tb_wishbone_gpio_bank: directed vectors against a 4-channel and a 3-channel instance.
module tb_wishbone_gpio_bank;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0] sel = '0;
    logic we = 1'b0, cyc = 1'b0, stb = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
    logic [31:0] dat_o, dat3;
    logic ack_o, err_o, rty_o, irq_o, ack3, err3, rty3, irq3;
    logic [1:0] tgd_o, tgd3;
    logic [127:0] in_i = '0, out_o;
    logic [95:0] in3 = '0, out3;
    logic r_ack, r_err, r_ack2;
    logic [31:0] r_dat;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    wishbone_gpio_bank dut (
        .clk_i(clk), .reset_n(reset_n), .adr_i(adr), .dat_i(dat), .sel_i(sel),
        .we_i(we), .cyc_i(cyc), .stb_i(stb), .dat_o(dat_o), .ack_o(ack_o),
        .err_o(err_o), .rty_o(rty_o), .tgd_o(tgd_o), .in_i(in_i), .out_o(out_o),
        .irq_o(irq_o)
    );

    wishbone_gpio_bank #(.CHANNELS(3)) dut3 (
        .clk_i(clk), .reset_n(reset_n), .adr_i(adr), .dat_i(dat), .sel_i(sel),
        .we_i(we), .cyc_i(cyc3), .stb_i(stb3), .dat_o(dat3), .ack_o(ack3),
        .err_o(err3), .rty_o(rty3), .tgd_o(tgd3), .in_i(in3), .out_o(out3),
        .irq_o(irq3)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, input bit three = 1'b0);
        adr = a; dat = d; sel = s; we = w;
        if (three) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else begin cyc = 1'b1; stb = 1'b1; end
        @(posedge clk); #1;
        r_ack = three ? ack3 : ack_o;
        r_err = three ? err3 : err_o;
        r_dat = three ? dat3 : dat_o;
        cyc = 1'b0; stb = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        r_ack2 = three ? ack3 : ack_o;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_out", out_o, 0);
        chk("rty_tgd", {rty_o, tgd_o}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        wb(8'h40, 32'hF0, 4'hF, 1'b1);
        chk("load_ack", r_ack, 1);
        chk("load_err", r_err, 0);
        chk("load_out", out_o[63:32], 32'hF0);
        chk("ack_one_cycle", r_ack2, 0);
        wb(8'h44, 32'h0F, 4'hF, 1'b1);
        chk("or_out", out_o[63:32], 32'hFF);
        wb(8'h48, 32'h3C, 4'hF, 1'b1);
        chk("andnot_out", out_o[63:32], 32'hC3);
        wb(8'h4C, 32'hFF, 4'hF, 1'b1);
        chk("xor_out", out_o[63:32], 32'h3C);
        wb(8'h40, 32'h0, 4'hF, 1'b0);
        chk("rd_out_ack", r_ack, 1);
        chk("rd_out_dat", r_dat, 32'h3C);
        chk("idle_dat", dat_o, 0);

        wb(8'h00, 32'hAABBCCDD, 4'b0010, 1'b1);
        chk("lane_out", out_o[31:0], 32'h0000CC00);

        wb(8'hB0, 32'h20, 4'hF, 1'b1);
        in_i[69] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_not_yet", irq_o, 0);
        wb(8'hA0, 32'h0, 4'hF, 1'b0);
        chk("stat_rd", r_dat, 32'h20);
        chk("irq_set", irq_o, 1);
        wb(8'hA0, 32'h20, 4'hF, 1'b1);
        chk("w1c_irq", irq_o, 0);
        wb(8'hA0, 32'h0, 4'hF, 1'b0);
        chk("w1c_stat", r_dat, 32'h0);

        in_i[69] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_i[69] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb(8'hA0, 32'h20, 4'hF, 1'b1);
        wb(8'hA0, 32'h0, 4'hF, 1'b0);
        chk("w1c_vs_rise", r_dat, 32'h20);

        wb(8'h50, 32'h1234, 4'hF, 1'b1);
        chk("in_wr_err", r_err, 1);
        chk("in_wr_ack", r_ack, 0);
        chk("in_wr_out", out_o, {32'h0, 32'h0, 32'h3C, 32'h0000CC00});
        wb(8'h90, 32'h0, 4'hF, 1'b0);
        chk("in_rd", r_dat, 32'h20);

        wb(8'hC0, 32'hFF, 4'hF, 1'b1, 1'b1);
        chk("ch3_err", r_err, 1);
        chk("ch3_ack", r_ack, 0);
        chk("ch3_out", out3, 0);
        wb(8'h80, 32'h11, 4'hF, 1'b1, 1'b1);
        chk("c3_ack", r_ack, 1);
        chk("c3_out", out3[95:64], 32'h11);

        chk("irq_pre_rst", irq_o, 1);
        adr = 8'h40; dat = 32'h55; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rstwr_ack", ack_o, 0);
        chk("rstwr_out", out_o[63:32], 32'h0);
        chk("rstwr_irq", irq_o, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstwr_noack", ack_o, 0);
        @(posedge clk); #1;
        wb(8'hA0, 32'h0, 4'hF, 1'b0);
        chk("held_stat_early", r_dat, 32'h0);
        wb(8'hA0, 32'h0, 4'hF, 1'b0);
        chk("held_stat_set", r_dat, 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
